// File: rtl/riscv_pkg.sv
// Shared pipeline types and constants for the RV32 core: NOP, reset PC and the F->D payload.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // addi x0,x0,0 with zeroed PC fields marks an empty decode slot
  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage and a combinational instruction RAM.
interface fetch_stage_if #(
  parameter int IMEM_AW    = 8,
  parameter int DATA_WIDTH = 32
);

  logic [IMEM_AW-1:0]    imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// F->D pipeline register; priority reset > flush > stall > load.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush_i,
  input  logic   stall_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t fd_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fd_q <= IF_ID_BUBBLE;
    end else if (flush_i) begin
      fd_q <= IF_ID_BUBBLE;
    end else if (!stall_i) begin
      fd_q <= d_i;
    end
  end

  assign q_o = fd_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, sticky misaligned-redirect flag and F->D register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       IMEM_AW       = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = RESET_PC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  fetch_stage_if.master            imem,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output logic                     misalign_err
);

  logic [ADDRESS_WIDTH-1:0] pcf_q, pcf_d;
  logic [ADDRESS_WIDTH-1:0] pcf_plus4;
  logic                     misalign_q, misalign_d;
  if_id_t                   fd_d, fd_q;

  always_comb begin
    pcf_plus4 = pcf_q + ADDRESS_WIDTH'(4);

    // A redirect overrides a fetch stall; the low two target bits are dropped
    if (PCSrcE) begin
      pcf_d = {PCTargetE[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (StallF) begin
      pcf_d = pcf_q;
    end else begin
      pcf_d = pcf_plus4;
    end

    misalign_d = misalign_q | (PCSrcE & (|PCTargetE[1:0]));

    fd_d = '{
      instr:    imem.imem_rdata,
      pc:       pcf_q,
      pc_plus4: pcf_plus4,
      valid:    1'b1
    };
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcf_q      <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      misalign_q <= misalign_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (FlushD),
    .stall_i (StallD),
    .d_i     (fd_d),
    .q_o     (fd_q)
  );

  assign imem.imem_addr = pcf_q[IMEM_AW-1:0];
  assign InstrD         = fd_q.instr;
  assign PCD            = fd_q.pc;
  assign PCPlus4D       = fd_q.pc_plus4;
  assign ValidD         = fd_q.valid;
  assign misalign_err   = misalign_q;

endmodule
